// File: rtl/dl_path_gain_tdm.sv
// Per-antenna complex gain for a TDM antenna-interleaved I/Q stream.
// The gain table is double-buffered and committed on frame heads. The fixed 4-cycle pipeline has a bypass path.
module dl_path_gain_tdm #(
    parameter int NANT = 8,
    parameter int CW   = 4,
    parameter int DW   = 16,
    parameter int GW   = 16,
    parameter int FRAC = 14
) (
    input  logic            clk,
    input  logic            asy_rst,
    input  logic            i_fram_hd,
    input  logic            i_ant8_sel,
    input  logic [2*DW-1:0] i_data,
    input  logic            i_data_valid,
    input  logic            i_bypass,
    input  logic            cfg_we,
    input  logic [CW-1:0]   cfg_addr,
    input  logic [2*GW-1:0] cfg_wdata,
    output logic            o_fram_hd,
    output logic            o_ant8_sel,
    output logic [CW-1:0]   o_ant_idx,
    output logic [2*DW-1:0] o_data,
    output logic            o_data_valid,
    output logic            o_sat
);

    localparam int PW  = DW + GW;
    localparam int SW  = DW + GW + 1;
    localparam int CTW = CW + 4;
    localparam logic [2*GW-1:0]   UNITY    = {GW'(2**FRAC), GW'(0)};
    localparam logic signed [SW-1:0] RND_HALF = SW'(2**(FRAC-1));
    localparam logic signed [SW-1:0] SAT_MAX  = SW'((2**(DW-1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN  = ~SAT_MAX;

    // Returns {clipped, value}.
    function automatic logic [DW:0] round_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        r = (v + RND_HALF) >>> FRAC;
        if (r > SAT_MAX)
            return {1'b1, SAT_MAX[DW-1:0]};
        else if (r < SAT_MIN)
            return {1'b1, SAT_MIN[DW-1:0]};
        else
            return {1'b0, r[DW-1:0]};
    endfunction

    logic [2*GW-1:0] shadow_q [NANT];
    logic [2*GW-1:0] shadow_d [NANT];
    logic [2*GW-1:0] active_q [NANT];
    logic [2*GW-1:0] active_d [NANT];
    logic [CW-1:0]   cnt_q, cnt_d, idx;
    logic            commit;
    logic [2*GW-1:0] gain_sel;

    // Control word layout: {valid, head, sel, bypass, idx}
    logic [CTW-1:0]  ctl1_q, ctl1_d, ctl2_q, ctl2_d, ctl3_q, ctl3_d;
    logic [2*DW-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [2*GW-1:0] g1_q, g1_d;
    logic signed [PW-1:0] p_ii_q, p_ii_d, p_qq_q, p_qq_d, p_iq_q, p_iq_d, p_qi_q, p_qi_d;
    logic signed [SW-1:0] re_q, re_d, im_q, im_d;
    logic signed [DW-1:0] s1_i, s1_q;
    logic signed [GW-1:0] s1_gi, s1_gq;
    logic [DW:0]     rs_re, rs_im;

    logic            out_vld_q, out_vld_d, out_hd_q, out_hd_d, out_sel_q, out_sel_d;
    logic            out_sat_q, out_sat_d;
    logic [CW-1:0]   out_idx_q, out_idx_d;
    logic [2*DW-1:0] out_data_q, out_data_d;

    always_comb begin
        commit = i_data_valid & i_fram_hd;
        idx    = commit ? '0 : cnt_q;

        cnt_d = cnt_q;
        if (i_data_valid) begin
            if (i_fram_hd)
                cnt_d = CW'(1);
            else if (cnt_q == CW'(NANT-1))
                cnt_d = '0;
            else
                cnt_d = cnt_q + CW'(1);
        end

        // The head sample reads shadow directly because active is only loaded at this edge.
        gain_sel = shadow_q[0];
        for (int k = 0; k < NANT; k++) begin
            shadow_d[k] = (cfg_we && cfg_addr == CW'(k)) ? cfg_wdata : shadow_q[k];
            active_d[k] = commit ? shadow_q[k] : active_q[k];
            if (!commit && idx == CW'(k))
                gain_sel = active_q[k];
        end

        ctl1_d = {i_data_valid, i_fram_hd, i_ant8_sel, i_bypass, idx};
        d1_d   = i_data;
        g1_d   = gain_sel;

        s1_i   = d1_q[2*DW-1:DW];
        s1_q   = d1_q[DW-1:0];
        s1_gi  = g1_q[2*GW-1:GW];
        s1_gq  = g1_q[GW-1:0];
        p_ii_d = PW'(s1_i) * PW'(s1_gi);
        p_qq_d = PW'(s1_q) * PW'(s1_gq);
        p_iq_d = PW'(s1_i) * PW'(s1_gq);
        p_qi_d = PW'(s1_q) * PW'(s1_gi);
        ctl2_d = ctl1_q;
        d2_d   = d1_q;

        re_d   = SW'(p_ii_q) - SW'(p_qq_q);
        im_d   = SW'(p_iq_q) + SW'(p_qi_q);
        ctl3_d = ctl2_q;
        d3_d   = d2_q;

        rs_re     = round_sat(re_q);
        rs_im     = round_sat(im_q);
        out_vld_d = ctl3_q[CTW-1];
        out_hd_d  = ctl3_q[CTW-2];
        out_sel_d = ctl3_q[CTW-3];
        out_idx_d = ctl3_q[CW-1:0];
        if (ctl3_q[CTW-4]) begin
            out_data_d = d3_q;
            out_sat_d  = 1'b0;
        end else begin
            out_data_d = {rs_re[DW-1:0], rs_im[DW-1:0]};
            out_sat_d  = ctl3_q[CTW-1] & (rs_re[DW] | rs_im[DW]);
        end
    end

    always_ff @(posedge clk) begin
        if (asy_rst) begin
            cnt_q <= '0;
            for (int k = 0; k < NANT; k++) begin
                shadow_q[k] <= UNITY;
                active_q[k] <= UNITY;
            end
            ctl1_q <= '0; ctl2_q <= '0; ctl3_q <= '0;
            d1_q   <= '0; d2_q   <= '0; d3_q   <= '0;
            g1_q   <= '0;
            p_ii_q <= '0; p_qq_q <= '0; p_iq_q <= '0; p_qi_q <= '0;
            re_q   <= '0; im_q   <= '0;
            out_vld_q  <= 1'b0;
            out_hd_q   <= 1'b0;
            out_sel_q  <= 1'b0;
            out_sat_q  <= 1'b0;
            out_idx_q  <= '0;
            out_data_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < NANT; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            ctl1_q <= ctl1_d; ctl2_q <= ctl2_d; ctl3_q <= ctl3_d;
            d1_q   <= d1_d;   d2_q   <= d2_d;   d3_q   <= d3_d;
            g1_q   <= g1_d;
            p_ii_q <= p_ii_d; p_qq_q <= p_qq_d; p_iq_q <= p_iq_d; p_qi_q <= p_qi_d;
            re_q   <= re_d;   im_q   <= im_d;
            out_vld_q  <= out_vld_d;
            out_hd_q   <= out_hd_d;
            out_sel_q  <= out_sel_d;
            out_sat_q  <= out_sat_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
        end
    end

    assign o_fram_hd    = out_hd_q;
    assign o_ant8_sel   = out_sel_q;
    assign o_ant_idx    = out_idx_q;
    assign o_data       = out_data_q;
    assign o_data_valid = out_vld_q;
    assign o_sat        = out_sat_q;

endmodule
